ei_axi4_if_checker: RTL and testbench

// - Passive AXI4 protocol checker for one master/slave link. Observes handshake and burst

---
 rtl/ei_axi4_if_checker.sv | 255 +++++++++++++++++++++++++
 tb/tb_ei_axi4_if_checker.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ei_axi4_if_checker.sv
// ei_axi4_if_checker: passive AXI4 protocol checker for one master/slave link.
// Watches handshakes, payload stability and burst framing, and raises sticky
// error flags in err_status. It drives no AXI signal.
// Optional feature: define EI_AXI4_TIMEOUT_EN to enable per-channel
// VALID-without-READY watchdogs (err_status[10]); otherwise bit 10 is tied 0.
// MAX_OUTST must be a power of 2, at least 2.
module ei_axi4_if_checker #(
    parameter int unsigned MAX_OUTST = 8,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned TIMEOUT   = 256
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              awvalid,
    input  logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [7:0]        awlen,
    input  logic [1:0]        awburst,
    input  logic              wvalid,
    input  logic              wready,
    input  logic              wlast,
    input  logic              bvalid,
    input  logic              bready,
    input  logic              arvalid,
    input  logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [7:0]        arlen,
    input  logic              rvalid,
    input  logic              rready,
    input  logic              rlast,
    output logic [10:0]       err_status,
    output logic              err_any
);

    localparam int unsigned PTR_W = $clog2(MAX_OUTST);
    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign b_hs  = bvalid & bready;
    assign ar_hs = arvalid & arready;
    assign r_hs  = rvalid & rready;

    // ---------------- payload stability ----------------
    logic              aw_stall, w_stall, b_stall, ar_stall, r_stall;
    logic [ADDR_W-1:0] aw_addr_q, ar_addr_q;
    logic [7:0]        aw_len_q, ar_len_q;
    logic [1:0]        aw_burst_q;
    logic              w_last_q, r_last_q;

    // Remember which channels were stalled last edge, and what they carried
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_stall   <= 1'b0;
            w_stall    <= 1'b0;
            b_stall    <= 1'b0;
            ar_stall   <= 1'b0;
            r_stall    <= 1'b0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_burst_q <= '0;
            w_last_q   <= 1'b0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            r_last_q   <= 1'b0;
        end else begin
            aw_stall   <= awvalid & ~awready;
            w_stall    <= wvalid & ~wready;
            b_stall    <= bvalid & ~bready;
            ar_stall   <= arvalid & ~arready;
            r_stall    <= rvalid & ~rready;
            aw_addr_q  <= awaddr;
            aw_len_q   <= awlen;
            aw_burst_q <= awburst;
            w_last_q   <= wlast;
            ar_addr_q  <= araddr;
            ar_len_q   <= arlen;
            r_last_q   <= rlast;
        end
    end

    logic e_aw, e_w, e_b, e_ar, e_r, e_burst;
    assign e_aw = aw_stall & (~awvalid | (awaddr != aw_addr_q) | (awlen != aw_len_q) |
                              (awburst != aw_burst_q));
    assign e_w  = w_stall & (~wvalid | (wlast != w_last_q));
    assign e_b  = b_stall & ~bvalid;
    assign e_ar = ar_stall & (~arvalid | (araddr != ar_addr_q) | (arlen != ar_len_q));
    assign e_r  = r_stall & (~rvalid | (rlast != r_last_q));
    assign e_burst = aw_hs & ((awburst == 2'b11) |
                     ((awburst == 2'b10) & ~((awlen == 8'd1) | (awlen == 8'd3) |
                                             (awlen == 8'd7) | (awlen == 8'd15))));

    // ---------------- AW length queue and W framing ----------------
    logic [7:0]       aw_mem [MAX_OUTST];
    logic [PTR_W-1:0] aw_wr, aw_rd;
    logic [CNT_W-1:0] aw_cnt;
    logic [7:0]       w_beat, w_head;
    logic             aw_empty, aw_full, w_has, w_final, w_pop, aw_push;
    logic             e_wlast, e_worph, e_awfull;

    // An empty queue with a same-cycle AW push serves the incoming length directly
    assign aw_empty = (aw_cnt == '0);
    assign aw_full  = (aw_cnt == CNT_W'(MAX_OUTST));
    assign w_head   = aw_empty ? awlen : aw_mem[aw_rd];
    assign w_has    = ~aw_empty | aw_hs;
    assign w_final  = (w_beat == w_head);
    assign w_pop    = w_hs & w_has & w_final;
    assign aw_push  = aw_hs & (~aw_full | w_pop);
    assign e_wlast  = w_hs & w_has & (wlast != w_final);
    assign e_worph  = w_hs & ~w_has;
    assign e_awfull = aw_hs & aw_full & ~w_pop;

    // AW length storage (contents need no reset; pointers define validity)
    always_ff @(posedge aclk) begin
        if (aw_push) aw_mem[aw_wr] <= awlen;
    end

    // AW queue pointers, occupancy and W beat counter
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_wr  <= '0;
            aw_rd  <= '0;
            aw_cnt <= '0;
            w_beat <= '0;
        end else begin
            if (aw_push) aw_wr <= aw_wr + 1'b1;
            if (w_pop)   aw_rd <= aw_rd + 1'b1;
            case ({aw_push, w_pop})
                2'b10:   aw_cnt <= aw_cnt + 1'b1;
                2'b01:   aw_cnt <= aw_cnt - 1'b1;
                default: aw_cnt <= aw_cnt;
            endcase
            if (w_hs & w_has) w_beat <= w_final ? '0 : w_beat + 1'b1;
        end
    end

    // ---------------- pending B responses ----------------
    logic [CNT_W-1:0] b_pend;
    logic             b_ok, b_inc_ok, e_borph, e_bovf;
    assign b_ok     = b_hs & (b_pend != '0);
    assign e_borph  = b_hs & (b_pend == '0);
    assign e_bovf   = w_pop & (b_pend == CNT_W'(MAX_OUTST)) & ~b_ok;
    assign b_inc_ok = w_pop & ~e_bovf;

    // Saturating count of completed write bursts awaiting B
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            b_pend <= '0;
        end else begin
            case ({b_inc_ok, b_ok})
                2'b10:   b_pend <= b_pend + 1'b1;
                2'b01:   b_pend <= b_pend - 1'b1;
                default: b_pend <= b_pend;
            endcase
        end
    end

    // ---------------- AR length queue and R framing ----------------
    logic [7:0]       ar_mem [MAX_OUTST];
    logic [PTR_W-1:0] ar_wr, ar_rd;
    logic [CNT_W-1:0] ar_cnt;
    logic [7:0]       r_beat, r_head;
    logic             ar_empty, ar_full, r_has, r_final, r_pop, ar_push;
    logic             e_rlast, e_arfull;

    assign ar_empty = (ar_cnt == '0);
    assign ar_full  = (ar_cnt == CNT_W'(MAX_OUTST));
    assign r_head   = ar_empty ? arlen : ar_mem[ar_rd];
    assign r_has    = ~ar_empty | ar_hs;
    assign r_final  = (r_beat == r_head);
    assign r_pop    = r_hs & r_has & r_final;
    assign ar_push  = ar_hs & (~ar_full | r_pop);
    assign e_rlast  = r_hs & (~r_has | (rlast != r_final));
    assign e_arfull = ar_hs & ar_full & ~r_pop;

    // AR length storage
    always_ff @(posedge aclk) begin
        if (ar_push) ar_mem[ar_wr] <= arlen;
    end

    // AR queue pointers, occupancy and R beat counter
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ar_wr  <= '0;
            ar_rd  <= '0;
            ar_cnt <= '0;
            r_beat <= '0;
        end else begin
            if (ar_push) ar_wr <= ar_wr + 1'b1;
            if (r_pop)   ar_rd <= ar_rd + 1'b1;
            case ({ar_push, r_pop})
                2'b10:   ar_cnt <= ar_cnt + 1'b1;
                2'b01:   ar_cnt <= ar_cnt - 1'b1;
                default: ar_cnt <= ar_cnt;
            endcase
            if (r_hs & r_has) r_beat <= r_final ? '0 : r_beat + 1'b1;
        end
    end

    // ---------------- optional VALID-wait watchdog ----------------
    logic e_to;
`ifdef EI_AXI4_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    logic [4:0]      ch_wait;
    logic [TO_W-1:0] to_cnt [5];
    assign ch_wait = {rvalid & ~rready, arvalid & ~arready, bvalid & ~bready,
                      wvalid & ~wready, awvalid & ~awready};

    // Per-channel stall counters, cleared whenever the channel is not waiting
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int unsigned i = 0; i < 5; i++) to_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 5; i++) begin
                if (!ch_wait[i])                        to_cnt[i] <= '0;
                else if (to_cnt[i] != TO_W'(TIMEOUT))   to_cnt[i] <= to_cnt[i] + 1'b1;
            end
        end
    end

    // Flag the edge on which a channel's wait count reaches TIMEOUT
    always_comb begin
        e_to = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            if (ch_wait[i] && ((32'(to_cnt[i]) + 32'd1) >= TIMEOUT)) e_to = 1'b1;
        end
    end
`else
    // TIMEOUT only matters with the watchdog built in
    assign e_to = (TIMEOUT == 32'd0) & 1'b0;
`endif

    // ---------------- sticky error register ----------------
    logic [10:0] err_new;
    assign err_new = {e_to,
                      e_awfull | e_arfull | e_bovf,
                      e_worph | e_borph,
                      e_rlast,
                      e_wlast,
                      e_burst,
                      e_r, e_ar, e_b, e_w, e_aw};

    // Accumulate errors until reset; err_any tracks the same edge
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_status <= '0;
            err_any    <= 1'b0;
        end else begin
            err_status <= err_status | err_new;
            err_any    <= |(err_status | err_new);
        end
    end

endmodule

// File: tb/tb_ei_axi4_if_checker.sv
// tb_ei_axi4_if_checker: directed scenarios plus randomized traffic checked
// against a transaction-level reference model built from queues of burst lengths.
module tb_ei_axi4_if_checker;

    localparam int MAXO   = 8;
    localparam int TO_LIM = 4;
`ifdef EI_AXI4_TIMEOUT_EN
    localparam logic [10:0] TO_BIT = 11'h400;
`else
    localparam logic [10:0] TO_BIT = 11'h000;
`endif

    logic        aclk;
    logic        aresetn;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [1:0]  awburst;
    logic [10:0] err_status;
    logic        err_any;

    int total = 0;
    int bad   = 0;

    ei_axi4_if_checker #(.MAX_OUTST(MAXO), .ADDR_W(32), .TIMEOUT(TO_LIM)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wlast(wlast),
        .bvalid(bvalid), .bready(bready),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rlast(rlast),
        .err_status(err_status), .err_any(err_any)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    logic [10:0] m_exp;
    int          m_aw_q[$];
    int          m_ar_q[$];
    int          m_wbeat, m_rbeat, m_pend;
    bit          m_aw_st, m_w_st, m_b_st, m_ar_st, m_r_st;
    logic [31:0] m_awaddr, m_araddr;
    logic [7:0]  m_awlen, m_arlen;
    logic [1:0]  m_awburst;
    logic        m_wlast, m_rlast;
    int          m_wait[5];

    task automatic model_reset();
        m_exp = '0;
        m_aw_q.delete();
        m_ar_q.delete();
        m_wbeat = 0; m_rbeat = 0; m_pend = 0;
        m_aw_st = 0; m_w_st = 0; m_b_st = 0; m_ar_st = 0; m_r_st = 0;
        for (int i = 0; i < 5; i++) m_wait[i] = 0;
    endtask

    // One clock edge of protocol rules applied to the currently driven inputs
    task automatic model_edge();
        logic [10:0] e;
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs, w_done, aw_used, ar_used;
        bit waiting[5];
        int head;
        e = '0;
        aw_hs = awvalid && awready; w_hs = wvalid && wready; b_hs = bvalid && bready;
        ar_hs = arvalid && arready; r_hs = rvalid && rready;
        w_done = 0; aw_used = 0; ar_used = 0;

        if (m_aw_st && (!awvalid || awaddr !== m_awaddr || awlen !== m_awlen || awburst !== m_awburst)) e[0] = 1;
        if (m_w_st && (!wvalid || wlast !== m_wlast)) e[1] = 1;
        if (m_b_st && !bvalid) e[2] = 1;
        if (m_ar_st && (!arvalid || araddr !== m_araddr || arlen !== m_arlen)) e[3] = 1;
        if (m_r_st && (!rvalid || rlast !== m_rlast)) e[4] = 1;

        if (aw_hs && (awburst == 2'b11 ||
            (awburst == 2'b10 && !(awlen == 1 || awlen == 3 || awlen == 7 || awlen == 15)))) e[5] = 1;

        // write data beats against the oldest write burst
        if (w_hs) begin
            if (m_aw_q.size() == 0 && !aw_hs) e[8] = 1;
            else begin
                head = (m_aw_q.size() != 0) ? m_aw_q[0] : int'(awlen);
                if (m_wbeat == head) begin
                    if (wlast !== 1'b1) e[6] = 1;
                    m_wbeat = 0;
                    w_done = 1;
                    if (m_aw_q.size() != 0) void'(m_aw_q.pop_front());
                    else aw_used = 1;
                end else begin
                    if (wlast !== 1'b0) e[6] = 1;
                    m_wbeat++;
                end
            end
        end
        if (aw_hs && !aw_used) begin
            if (m_aw_q.size() >= MAXO) e[9] = 1;
            else m_aw_q.push_back(int'(awlen));
        end

        if (b_hs) begin
            if (m_pend == 0) e[8] = 1;
            else m_pend--;
        end
        if (w_done) begin
            if (m_pend == MAXO) e[9] = 1;
            else m_pend++;
        end

        // read data beats against the oldest read burst
        if (r_hs) begin
            if (m_ar_q.size() == 0 && !ar_hs) e[7] = 1;
            else begin
                head = (m_ar_q.size() != 0) ? m_ar_q[0] : int'(arlen);
                if (m_rbeat == head) begin
                    if (rlast !== 1'b1) e[7] = 1;
                    m_rbeat = 0;
                    if (m_ar_q.size() != 0) void'(m_ar_q.pop_front());
                    else ar_used = 1;
                end else begin
                    if (rlast !== 1'b0) e[7] = 1;
                    m_rbeat++;
                end
            end
        end
        if (ar_hs && !ar_used) begin
            if (m_ar_q.size() >= MAXO) e[9] = 1;
            else m_ar_q.push_back(int'(arlen));
        end

        waiting[0] = awvalid && !awready; waiting[1] = wvalid && !wready;
        waiting[2] = bvalid && !bready;   waiting[3] = arvalid && !arready;
        waiting[4] = rvalid && !rready;
`ifdef EI_AXI4_TIMEOUT_EN
        for (int i = 0; i < 5; i++) begin
            if (waiting[i]) begin
                m_wait[i]++;
                if (m_wait[i] >= TO_LIM) e[10] = 1;
            end else m_wait[i] = 0;
        end
`endif

        m_aw_st = waiting[0]; m_w_st = waiting[1]; m_b_st = waiting[2];
        m_ar_st = waiting[3]; m_r_st = waiting[4];
        m_awaddr = awaddr; m_awlen = awlen; m_awburst = awburst; m_wlast = wlast;
        m_araddr = araddr; m_arlen = arlen; m_rlast = rlast;
        m_exp = m_exp | e;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        awvalid = 0; awready = 0; awaddr = '0; awlen = '0; awburst = 2'b01;
        wvalid = 0; wready = 0; wlast = 0; bvalid = 0; bready = 0;
        arvalid = 0; arready = 0; araddr = '0; arlen = '0;
        rvalid = 0; rready = 0; rlast = 0;
    endtask

    task automatic tick();
        @(posedge aclk);
        model_edge();
        @(negedge aclk);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic drive_random();
        int r, head;
        // AW
        if (m_aw_st) begin
            r = $urandom_range(0, 59);
            if (r == 0) awvalid = 0;
            else if (r == 1) awaddr = awaddr ^ 32'h4;
        end else begin
            awvalid = ($urandom_range(0, 2) == 0);
            awaddr  = $urandom;
            r = $urandom_range(0, 3);
            awlen = (r == 0) ? 8'd0 : (r == 1) ? 8'd1 : (r == 2) ? 8'd3 : 8'd7;
            r = $urandom_range(0, 29);
            awburst = (r == 0) ? 2'b11 : (r < 5) ? 2'b10 : 2'b01;
        end
        awready = ($urandom_range(0, 1) == 1);
        // W
        if (m_w_st) begin
            r = $urandom_range(0, 59);
            if (r == 0) wvalid = 0;
            else if (r == 1) wlast = ~wlast;
        end else begin
            wvalid = ($urandom_range(0, 2) != 0) && (m_aw_q.size() > 0 || $urandom_range(0, 39) == 0);
            head = (m_aw_q.size() > 0) ? m_aw_q[0] : int'(awlen);
            wlast = (m_wbeat == head);
            if ($urandom_range(0, 39) == 0) wlast = ~wlast;
        end
        wready = ($urandom_range(0, 1) == 1);
        // B
        if (m_b_st) begin
            if ($urandom_range(0, 59) == 0) bvalid = 0;
        end else begin
            bvalid = ($urandom_range(0, 1) == 0) && (m_pend > 0 || $urandom_range(0, 39) == 0);
        end
        bready = ($urandom_range(0, 1) == 1);
        // AR
        if (m_ar_st) begin
            r = $urandom_range(0, 59);
            if (r == 0) arvalid = 0;
            else if (r == 1) arlen = arlen ^ 8'h1;
        end else begin
            arvalid = ($urandom_range(0, 2) == 0);
            araddr  = $urandom;
            arlen   = 8'($urandom_range(0, 3));
        end
        arready = ($urandom_range(0, 1) == 1);
        // R
        if (m_r_st) begin
            r = $urandom_range(0, 59);
            if (r == 0) rvalid = 0;
            else if (r == 1) rlast = ~rlast;
        end else begin
            rvalid = ($urandom_range(0, 2) != 0) && (m_ar_q.size() > 0 || $urandom_range(0, 39) == 0);
            head = (m_ar_q.size() > 0) ? m_ar_q[0] : int'(arlen);
            rlast = (m_rbeat == head);
            if ($urandom_range(0, 39) == 0) rlast = ~rlast;
        end
        rready = ($urandom_range(0, 1) == 1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        aresetn = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge aclk);
        total++;
        if (err_status !== 11'h000) begin
            bad++; $display("FAIL reset_status: got %h, required %h", err_status, 11'h000);
        end
        total++;
        if (err_any !== 1'b0) begin
            bad++; $display("FAIL reset_any: got %b, required 0", err_any);
        end
        aresetn = 1'b1;
    endtask

    task automatic test_clean_write();
        do_reset();
        awvalid = 1; awready = 1; awaddr = 32'h1000; awlen = 8'd3; awburst = 2'b01;
        tick();
        awvalid = 0; awready = 0;
        for (int b = 0; b < 4; b++) begin
            wvalid = 1; wready = 1; wlast = (b == 3);
            tick();
            total++;
            if (err_status !== 11'h000) begin
                bad++; $display("FAIL clean_write_beat%0d: got %h, required %h", b, err_status, 11'h000);
            end
        end
        wvalid = 0; wready = 0; wlast = 0;
        bvalid = 1; bready = 1;
        tick();
        bvalid = 0; bready = 0;
        tick();
        total++;
        if (err_status !== 11'h000 || err_any !== 1'b0) begin
            bad++; $display("FAIL clean_write_b: got %h/%b, required %h/0", err_status, err_any, 11'h000);
        end
    endtask

    task automatic test_aw_stability();
        do_reset();
        awvalid = 1; awready = 0; awaddr = 32'h100; awlen = 8'd0; awburst = 2'b01;
        tick();
        total++;
        if (err_status !== 11'h000) begin
            bad++; $display("FAIL aw_stall_ok: got %h, required %h", err_status, 11'h000);
        end
        awaddr = 32'h104;
        tick();
        total++;
        if (err_status !== 11'h001 || err_any !== 1'b1) begin
            bad++; $display("FAIL aw_addr_change: got %h/%b, required %h/1", err_status, err_any, 11'h001);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        awvalid = 1; awready = 1; awaddr = 32'h200; awlen = 8'd1; awburst = 2'b10;
        tick();
        total++;
        if (err_status !== 11'h000) begin
            bad++; $display("FAIL wrap_len1: got %h, required %h", err_status, 11'h000);
        end
        awaddr = 32'h300; awlen = 8'd2;
        tick();
        awvalid = 0; awready = 0;
        total++;
        if (err_status !== 11'h020) begin
            bad++; $display("FAIL wrap_len2: got %h, required %h", err_status, 11'h020);
        end
    endtask

    task automatic test_rlast();
        do_reset();
        arvalid = 1; arready = 1; araddr = 32'h40; arlen = 8'd0;
        tick();
        arvalid = 0; arready = 0;
        rvalid = 1; rready = 1; rlast = 0;
        tick();
        rvalid = 0; rready = 0;
        total++;
        if (err_status !== 11'h080) begin
            bad++; $display("FAIL rlast_low: got %h, required %h", err_status, 11'h080);
        end
        do_reset();
        rvalid = 1; rready = 1; rlast = 1;
        tick();
        rvalid = 0; rready = 0; rlast = 0;
        total++;
        if (err_status !== 11'h080) begin
            bad++; $display("FAIL r_no_ar: got %h, required %h", err_status, 11'h080);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            awvalid = 1; awready = 1; awaddr = 32'h1000 + 32'(i * 16); awlen = 8'd0; awburst = 2'b01;
            tick();
            if (i == 7) begin
                total++;
                if (err_status !== 11'h000) begin
                    bad++; $display("FAIL overflow_8th: got %h, required %h", err_status, 11'h000);
                end
            end
        end
        awvalid = 0; awready = 0;
        total++;
        if (err_status !== 11'h200) begin
            bad++; $display("FAIL overflow_9th: got %h, required %h", err_status, 11'h200);
        end
        // asynchronous reset between clock edges
        #2 aresetn = 1'b0;
        #1;
        total++;
        if (err_status !== 11'h000 || err_any !== 1'b0) begin
            bad++; $display("FAIL async_reset: got %h/%b, required %h/0", err_status, err_any, 11'h000);
        end
        model_reset();
        @(negedge aclk);
        aresetn = 1'b1;
        // stale queue contents must be gone: new len=1 burst frames cleanly
        awvalid = 1; awready = 1; awaddr = 32'h2000; awlen = 8'd1;
        tick();
        awvalid = 0; awready = 0;
        wvalid = 1; wready = 1; wlast = 0;
        tick();
        wlast = 1;
        tick();
        wvalid = 0; wready = 0; wlast = 0;
        total++;
        if (err_status !== 11'h000) begin
            bad++; $display("FAIL post_reset_burst: got %h, required %h", err_status, 11'h000);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        arvalid = 1; arready = 0; araddr = 32'h80; arlen = 8'd0;
        for (int c = 1; c <= TO_LIM; c++) begin
            tick();
            if (c == TO_LIM - 1) begin
                total++;
                if (err_status !== 11'h000) begin
                    bad++; $display("FAIL timeout_early: got %h, required %h", err_status, 11'h000);
                end
            end
        end
        total++;
        if (err_status !== TO_BIT) begin
            bad++; $display("FAIL timeout_reach: got %h, required %h", err_status, TO_BIT);
        end
        arready = 1;
        tick();
        arvalid = 0; arready = 0;
    endtask

    task automatic test_random();
        for (int ep = 0; ep < 25; ep++) begin
            do_reset();
            for (int c = 0; c < 40; c++) begin
                drive_random();
                tick();
                total++;
                if (err_status !== m_exp) begin
                    bad++; $display("FAIL random_status ep%0d cyc%0d: got %h, required %h", ep, c, err_status, m_exp);
                end
                total++;
                if (err_any !== (|m_exp)) begin
                    bad++; $display("FAIL random_any ep%0d cyc%0d: got %b, required %b", ep, c, err_any, |m_exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_write();
        test_aw_stability();
        test_wrap();
        test_rlast();
        test_overflow();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
